// File: rtl/braille_digit_decoder.sv
// Braille digit decoder: turns a stream of 6-dot Braille cells into BCD digits
// for a 7-segment display, tracking text / number / error context.
module braille_digit_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] cell_in,
    input  logic       cell_valid,
    output logic       cell_ready,
    output logic [3:0] bcd,
    output logic       bcd_valid,
    output logic       blank,
    output logic       num_mode,
    output logic [2:0] digit_cnt,
    output logic       err
);

    localparam int unsigned CELL_W = 6;
    localparam int unsigned BCD_W  = 4;
    localparam int unsigned CNT_W  = 3;

    localparam logic [CELL_W-1:0] CELL_NUMSIGN = CELL_W'(6'h3C);
    localparam logic [CELL_W-1:0] CELL_SPACE   = CELL_W'(6'h00);
    localparam logic [BCD_W-1:0]  BCD_OFF      = BCD_W'(4'hF);
    localparam logic [CNT_W-1:0]  CNT_MAX      = CNT_W'(3'd7);

    // Each non-TEXT state owns one bit so num_mode/err are single flop outputs.
    typedef enum logic [1:0] {
        ST_TEXT = 2'b00,
        ST_NUM  = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    state_t             r_state;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_bcd_valid;
    logic               r_blank;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;

    state_t             w_state_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               w_bcd_valid_nxt;
    logic               w_blank_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ready_nxt;
    logic               w_accept;
    logic               w_is_digit;
    logic [BCD_W-1:0]   w_digit;

    assign w_accept = cell_valid & r_ready;

    // Digit cells (Braille letters a..j)
    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = BCD_W'(0);
        case (cell_in)
            6'h01:   w_digit = BCD_W'(1);
            6'h03:   w_digit = BCD_W'(2);
            6'h09:   w_digit = BCD_W'(3);
            6'h19:   w_digit = BCD_W'(4);
            6'h11:   w_digit = BCD_W'(5);
            6'h0B:   w_digit = BCD_W'(6);
            6'h1B:   w_digit = BCD_W'(7);
            6'h13:   w_digit = BCD_W'(8);
            6'h0A:   w_digit = BCD_W'(9);
            6'h1A:   w_digit = BCD_W'(0);
            default: w_is_digit = 1'b0;
        endcase
    end

    // Next-state and next-output logic; only an accepted cell moves anything.
    always_comb begin
        w_state_nxt     = r_state;
        w_bcd_nxt       = r_bcd;
        w_bcd_valid_nxt = 1'b0;
        w_blank_nxt     = r_blank;
        w_cnt_nxt       = r_cnt;
        w_ready_nxt     = ~w_accept;

        if (w_accept) begin
            case (r_state)
                ST_TEXT: begin
                    if (cell_in == CELL_NUMSIGN) begin
                        w_state_nxt = ST_NUM;
                        w_cnt_nxt   = CNT_W'(0);
                    end
                end
                ST_NUM: begin
                    if (w_is_digit) begin
                        w_bcd_nxt       = w_digit;
                        w_bcd_valid_nxt = 1'b1;
                        w_blank_nxt     = 1'b0;
                        w_cnt_nxt       = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                    end else if (cell_in == CELL_SPACE) begin
                        w_state_nxt = ST_TEXT;
                        w_blank_nxt = 1'b1;
                    end else if (cell_in == CELL_NUMSIGN) begin
                        w_cnt_nxt = CNT_W'(0);
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_bcd_nxt   = BCD_OFF;
                        w_blank_nxt = 1'b1;
                    end
                end
                ST_ERR: begin
                    if (cell_in == CELL_SPACE) begin
                        w_state_nxt = ST_TEXT;
                    end
                end
                default: w_state_nxt = ST_TEXT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_TEXT;
            r_bcd       <= BCD_OFF;
            r_bcd_valid <= 1'b0;
            r_blank     <= 1'b1;
            r_cnt       <= CNT_W'(0);
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bcd       <= w_bcd_nxt;
            r_bcd_valid <= w_bcd_valid_nxt;
            r_blank     <= w_blank_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= w_ready_nxt;
        end
    end

    assign cell_ready = r_ready;
    assign bcd        = r_bcd;
    assign bcd_valid  = r_bcd_valid;
    assign blank      = r_blank;
    assign digit_cnt  = r_cnt;
    assign num_mode   = r_state[0];
    assign err        = r_state[1];

endmodule

// File: tb/tb_braille_digit_decoder.sv
// Scoreboard bench for braille_digit_decoder: directed scenarios plus random
// cell streams checked against a table-driven reference model.
module tb_braille_digit_decoder;

    logic       clk;
    logic       rst_n;
    logic [5:0] cell_in;
    logic       cell_valid;
    logic       cell_ready;
    logic [3:0] bcd;
    logic       bcd_valid;
    logic       blank;
    logic       num_mode;
    logic [2:0] digit_cnt;
    logic       err;

    braille_digit_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cell_in    (cell_in),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .blank      (blank),
        .num_mode   (num_mode),
        .digit_cnt  (digit_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Braille digit patterns indexed by digit value
    logic [5:0] pat [10] = '{6'h1A, 6'h01, 6'h03, 6'h09, 6'h19, 6'h11, 6'h0B, 6'h1B, 6'h13, 6'h0A};

    // Model: 0 = text, 1 = number, 2 = error
    int exp_mode, exp_bcd, exp_cnt;
    bit exp_valid, exp_blank, exp_ready;
    int sb [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [5:0] c);
        for (int d = 0; d < 10; d++) if (pat[d] == c) return d;
        return -1;
    endfunction

    task automatic model_reset();
        exp_mode = 0; exp_bcd = 15; exp_cnt = 0;
        exp_valid = 0; exp_blank = 1; exp_ready = 0;
    endtask

    task automatic model_cell(input logic [5:0] c);
        int d;
        d = digit_of(c);
        exp_valid = 0;
        case (exp_mode)
            0: if (c == 6'h3C) begin exp_mode = 1; exp_cnt = 0; end
            1: begin
                if (d >= 0) begin
                    exp_bcd = d; exp_valid = 1; exp_blank = 0;
                    exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
                    sb.push_back(d);
                end else if (c == 6'h00) begin
                    exp_mode = 0; exp_blank = 1;
                end else if (c == 6'h3C) begin
                    exp_cnt = 0;
                end else begin
                    exp_mode = 2; exp_bcd = 15; exp_blank = 1;
                end
            end
            default: if (c == 6'h00) exp_mode = 0;
        endcase
    endtask

    task automatic check_reset_values();
        chk("rst_bcd", int'(bcd), 15);
        chk("rst_bcd_valid", int'(bcd_valid), 0);
        chk("rst_blank", int'(blank), 1);
        chk("rst_num_mode", int'(num_mode), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_digit_cnt", int'(digit_cnt), 0);
        chk("rst_cell_ready", int'(cell_ready), 0);
    endtask

    // One cycle: compare outputs with the model, drive new inputs, advance the model.
    task automatic step(input logic v, input logic [5:0] c, output bit acc);
        @(negedge clk);
        chk("cell_ready", int'(cell_ready), int'(exp_ready));
        chk("bcd", int'(bcd), exp_bcd);
        chk("bcd_valid", int'(bcd_valid), int'(exp_valid));
        chk("blank", int'(blank), int'(exp_blank));
        chk("num_mode", int'(num_mode), int'(exp_mode == 1));
        chk("err", int'(err), int'(exp_mode == 2));
        chk("digit_cnt", int'(digit_cnt), exp_cnt);
        chk("bcd_range", int'(bcd > 4'd9 && bcd != 4'hF), 0);
        cell_valid = v;
        cell_in    = c;
        acc        = v && exp_ready;
        exp_valid  = 0;
        if (acc) model_cell(c);
        exp_ready  = !acc;
    endtask

    task automatic send(input logic [5:0] c);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, c, acc);
            n++;
        end while (!acc && n < 4);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 6'h00, acc);
    endtask

    task automatic mid_reset();
        bit acc;
        step(1'b0, 6'h00, acc);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        chk("ready_low_at_release", int'(cell_ready), 0);
        rst_n = 1'b1;
        exp_ready = 1;
    endtask

    // Monitor: every bcd_valid pulse must match the oldest queued digit.
    initial begin
        forever begin
            @(negedge clk);
            if (bcd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse bcd=%0d expected=none t=%0t", bcd, $time);
                end else begin
                    chk("pulse_bcd", int'(bcd), sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k;
        logic [5:0] c;
        cell_valid = 1'b0;
        cell_in    = 6'h00;
        rst_n      = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_reset_values();
        repeat (2) @(negedge clk);
        chk("ready_low_at_release", int'(cell_ready), 0);
        rst_n = 1'b1;
        exp_ready = 1;

        // Number sign then 1, 2
        send(6'h3C); send(6'h01); send(6'h03); idle(2);
        // Space ends the number; digits in text are ignored
        send(6'h00); send(6'h01); idle(2);
        // Bad cell inside a number, stuck in error until space
        send(6'h3C); send(6'h07); send(6'h01); send(6'h00); idle(2);
        // Valid held high over a continuous digit stream
        send(6'h3C);
        for (int i = 0; i < 6; i++) send(pat[$urandom_range(0, 9)]);
        send(6'h3C); idle(1);
        // Saturating digit count
        send(6'h00); send(6'h3C);
        for (int i = 0; i < 9; i++) send(6'h1A);
        idle(2);
        // Reset in the middle of a number showing 5
        send(6'h00); send(6'h3C); send(6'h11);
        mid_reset();
        idle(2);

        // Random cell streams
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            if (k < 2)       c = 6'h3C;
            else if (k < 6)  c = pat[$urandom_range(0, 9)];
            else if (k < 8)  c = 6'h00;
            else             c = 6'($urandom_range(0, 63));
            step(($urandom_range(0, 9) < 8) && (k != 9), c, acc);
            if (i % 200 == 150) mid_reset();
        end

        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
